// File: rtl/dport_req_buffer.sv
// Data-port request buffer: in-order request FIFO with an outstanding-request cap.
// Optional zero-latency bypass when empty is enabled by defining DPORT_BUF_BYPASS_EN.
module dport_req_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_wr_i,
  input  logic        core_rd_i,
  input  logic [3:0]  core_wr_i,
  input  logic        core_cacheable_i,
  input  logic [10:0] core_req_tag_i,
  input  logic        core_invalidate_i,
  input  logic        core_writeback_i,
  input  logic        core_flush_i,
  output logic        core_accept_o,
  output logic [31:0] core_data_rd_o,
  output logic        core_ack_o,
  output logic        core_error_o,
  output logic [10:0] core_resp_tag_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic        mem_cacheable_o,
  output logic [10:0] mem_req_tag_o,
  output logic        mem_invalidate_o,
  output logic        mem_writeback_o,
  output logic        mem_flush_o,
  input  logic        mem_accept_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [10:0] mem_resp_tag_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [3:0]       MAX_OUT  = 4'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic [10:0] tag;
    logic        invalidate;
    logic        writeback;
    logic        flush;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        outst_q, outst_d;

  entry_t core_entry, head, out_entry;
  logic   creq, full, empty, issue_ok, present, bypass;
  logic   push, pop, byp_issue, issue, ack_dec;

  always_comb begin
    creq = core_rd_i | (|core_wr_i) | core_invalidate_i | core_writeback_i | core_flush_i;
    core_entry = '{addr: core_addr_i, data_wr: core_data_wr_i, rd: core_rd_i, wr: core_wr_i,
                   cacheable: core_cacheable_i, tag: core_req_tag_i,
                   invalidate: core_invalidate_i, writeback: core_writeback_i,
                   flush: core_flush_i};
    full     = (cnt_q == FULL_CNT);
    empty    = (cnt_q == '0);
    issue_ok = (outst_q < MAX_OUT);
    head     = fifo_q[rd_ptr_q];
    core_accept_o = ~full & ~rst_i;

`ifdef DPORT_BUF_BYPASS_EN
    bypass    = empty & issue_ok & creq & ~rst_i;
    out_entry = bypass ? core_entry : head;
`else
    bypass    = 1'b0;
    out_entry = head;
`endif

    // Head and bypass are mutually exclusive: bypass only exists when the FIFO is empty.
    pop       = ~empty & issue_ok & ~rst_i & mem_accept_i;
    present   = (~empty & issue_ok & ~rst_i) | bypass;
    byp_issue = bypass & mem_accept_i;
    push      = creq & core_accept_o & ~byp_issue;
    issue     = pop | byp_issue;
    ack_dec   = mem_ack_i & (outst_q != 4'd0);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({issue, ack_dec})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    mem_addr_o       = out_entry.addr;
    mem_data_wr_o    = out_entry.data_wr;
    mem_cacheable_o  = out_entry.cacheable;
    mem_req_tag_o    = out_entry.tag;
    mem_rd_o         = present & out_entry.rd;
    mem_wr_o         = present ? out_entry.wr : 4'd0;
    mem_invalidate_o = present & out_entry.invalidate;
    mem_writeback_o  = present & out_entry.writeback;
    mem_flush_o      = present & out_entry.flush;

    core_data_rd_o  = mem_data_rd_i;
    core_ack_o      = mem_ack_i;
    core_error_o    = mem_error_i;
    core_resp_tag_o = mem_resp_tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= core_entry;
  end

endmodule

// File: tb/tb_dport_req_buffer.sv
// Directed bench for dport_req_buffer (default build, DEPTH=2, MAX_OUTSTANDING=2).
module tb_dport_req_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] core_addr_i, core_data_wr_i;
  logic        core_rd_i;
  logic [3:0]  core_wr_i;
  logic        core_cacheable_i;
  logic [10:0] core_req_tag_i;
  logic        core_invalidate_i, core_writeback_i, core_flush_i;
  logic        core_accept_o;
  logic [31:0] core_data_rd_o;
  logic        core_ack_o, core_error_o;
  logic [10:0] core_resp_tag_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic        mem_cacheable_o;
  logic [10:0] mem_req_tag_o;
  logic        mem_invalidate_o, mem_writeback_o, mem_flush_o;
  logic        mem_accept_i;
  logic [31:0] mem_data_rd_i;
  logic        mem_ack_i, mem_error_i;
  logic [10:0] mem_resp_tag_i;

  int errors = 0;
  int checks = 0;

  dport_req_buffer #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_addr_i(core_addr_i), .core_data_wr_i(core_data_wr_i), .core_rd_i(core_rd_i),
    .core_wr_i(core_wr_i), .core_cacheable_i(core_cacheable_i), .core_req_tag_i(core_req_tag_i),
    .core_invalidate_i(core_invalidate_i), .core_writeback_i(core_writeback_i),
    .core_flush_i(core_flush_i), .core_accept_o(core_accept_o), .core_data_rd_o(core_data_rd_o),
    .core_ack_o(core_ack_o), .core_error_o(core_error_o), .core_resp_tag_o(core_resp_tag_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_invalidate_o(mem_invalidate_o), .mem_writeback_o(mem_writeback_o),
    .mem_flush_o(mem_flush_o), .mem_accept_i(mem_accept_i), .mem_data_rd_i(mem_data_rd_i),
    .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i), .mem_resp_tag_i(mem_resp_tag_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        ack;
    logic        err;
    logic [10:0] tag;
    logic [31:0] exp_data;
    logic        exp_ack;
    logic        exp_err;
    logic [10:0] exp_tag;
  } resp_vec_t;

  resp_vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_req();
    core_rd_i = 1'b0; core_wr_i = 4'd0; core_invalidate_i = 1'b0;
    core_writeback_i = 1'b0; core_flush_i = 1'b0; core_cacheable_i = 1'b0;
  endtask

  task automatic rd_req(input logic [31:0] a, input logic [10:0] t);
    idle_req();
    core_rd_i = 1'b1; core_addr_i = a; core_req_tag_i = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 11'h000, 32'h0000_0000, 1'b0, 1'b0, 11'h000};
    vecs[1] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 11'h123, 32'hDEAD_BEEF, 1'b1, 1'b0, 11'h123};
    vecs[2] = '{32'h1234_5678, 1'b1, 1'b1, 11'h7FF, 32'h1234_5678, 1'b1, 1'b1, 11'h7FF};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 11'h400, 32'hFFFF_FFFF, 1'b0, 1'b1, 11'h400};
    vecs[4] = '{32'hA5A5_5A5A, 1'b1, 1'b0, 11'h001, 32'hA5A5_5A5A, 1'b1, 1'b0, 11'h001};
    vecs[5] = '{32'h0F0F_F0F0, 1'b1, 1'b1, 11'h2AA, 32'h0F0F_F0F0, 1'b1, 1'b1, 11'h2AA};

    rst_i = 1'b1;
    idle_req();
    core_addr_i = 32'h0; core_data_wr_i = 32'h0; core_req_tag_i = 11'h0;
    mem_accept_i = 1'b0; mem_data_rd_i = 32'h0; mem_ack_i = 1'b0;
    mem_error_i = 1'b0; mem_resp_tag_i = 11'h0;

    // Reset held three cycles with a request pending
    core_rd_i = 1'b1; core_wr_i = 4'hF; core_addr_i = 32'h80;
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_accept", core_accept_o, 0);
      chk("rst_mem_rd", mem_rd_o, 0);
      chk("rst_mem_wr", mem_wr_o, 0);
      if (i < 2) tick();
      else begin
        @(posedge clk_i); #1;
      end
    end
    rst_i = 1'b0;
    idle_req();
    #1;
    chk("post_rst_accept", core_accept_o, 1);
    chk("post_rst_mem_rd", mem_rd_o, 0);
    tick();

    // Response pass-through; these acks arrive with nothing outstanding
    for (int i = 0; i < 6; i++) begin
      mem_data_rd_i = vecs[i].data; mem_ack_i = vecs[i].ack;
      mem_error_i = vecs[i].err; mem_resp_tag_i = vecs[i].tag;
      #1;
      chk($sformatf("vec%0d_data", i), core_data_rd_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_ack", i), core_ack_o, vecs[i].exp_ack);
      chk($sformatf("vec%0d_err", i), core_error_o, vecs[i].exp_err);
      chk($sformatf("vec%0d_tag", i), core_resp_tag_o, vecs[i].exp_tag);
      chk($sformatf("vec%0d_mem_rd", i), mem_rd_o, 0);
      chk($sformatf("vec%0d_accept", i), core_accept_o, 1);
      tick();
    end
    mem_ack_i = 1'b0; mem_error_i = 1'b0;

    // Single read: one cycle latency, then response
    mem_accept_i = 1'b1;
    rd_req(32'h100, 11'h005);
    #1;
    chk("rd_accept", core_accept_o, 1);
    chk("rd_no_bypass", mem_rd_o, 0);
    tick();
    idle_req();
    #1;
    chk("rd_issue", mem_rd_o, 1);
    chk("rd_addr", mem_addr_o, 32'h100);
    chk("rd_tag", mem_req_tag_o, 32'h005);
    tick();
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b1; mem_resp_tag_i = 11'h005; mem_data_rd_i = 32'hCAFE_F00D;
    #1;
    chk("rd_idle", mem_rd_o, 0);
    chk("rd_ack", core_ack_o, 1);
    chk("rd_data", core_data_rd_o, 32'hCAFE_F00D);
    chk("rd_resp_tag", core_resp_tag_o, 32'h005);
    tick();
    mem_ack_i = 1'b0;

    // Maintenance ops carry their attribute fields through
    mem_accept_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle_req();
      core_addr_i = 32'h40 + 32'(i * 4);
      core_data_wr_i = (i == 0) ? 32'h1111_2222 : 32'h3333_4444;
      core_req_tag_i = 11'(16 + i);
      core_cacheable_i = (i == 0);
      core_invalidate_i = (i == 0); core_writeback_i = (i == 1); core_flush_i = (i == 0);
      tick();
      idle_req();
      #1;
      chk("op_inv", mem_invalidate_o, (i == 0) ? 1 : 0);
      chk("op_wb", mem_writeback_o, (i == 1) ? 1 : 0);
      chk("op_flush", mem_flush_o, (i == 0) ? 1 : 0);
      chk("op_cacheable", mem_cacheable_o, (i == 0) ? 1 : 0);
      chk("op_data", mem_data_wr_o, (i == 0) ? 32'h1111_2222 : 32'h3333_4444);
      chk("op_rd", mem_rd_o, 0);
      tick();
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
    end

    // FIFO fills while memory stalls, then drains in order
    mem_accept_i = 1'b0;
    idle_req();
    core_wr_i = 4'hF; core_addr_i = 32'h10; core_data_wr_i = 32'hA0;
    #1;
    chk("wr0_accept", core_accept_o, 1);
    tick();
    core_addr_i = 32'h14; core_data_wr_i = 32'hA4;
    #1;
    chk("wr1_accept", core_accept_o, 1);
    chk("wr_head_wr", mem_wr_o, 32'hF);
    chk("wr_head_addr", mem_addr_o, 32'h10);
    tick();
    core_addr_i = 32'h18; core_data_wr_i = 32'hA8;
    #1;
    chk("wr2_full", core_accept_o, 0);
    tick();
    mem_accept_i = 1'b1;
    #1;
    chk("drain0_accept", core_accept_o, 0);
    chk("drain0_addr", mem_addr_o, 32'h10);
    chk("drain0_wr", mem_wr_o, 32'hF);
    tick();
    #1;
    chk("drain1_addr", mem_addr_o, 32'h14);
    chk("drain1_accept", core_accept_o, 1);
    tick();
    idle_req();
    mem_ack_i = 1'b1;
    #1;
    chk("drain2_capped", mem_wr_o, 0);
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("drain2_addr", mem_addr_o, 32'h18);
    chk("drain2_wr", mem_wr_o, 32'hF);
    chk("drain2_data", mem_data_wr_o, 32'hA8);
    tick();
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b1;
    tick();
    tick();
    mem_ack_i = 1'b0;

    // Outstanding cap: third read held until an ack
    mem_accept_i = 1'b1;
    rd_req(32'h200, 11'h020);
    tick();
    rd_req(32'h204, 11'h021);
    #1;
    chk("cap0_addr", mem_addr_o, 32'h200);
    chk("cap0_rd", mem_rd_o, 1);
    tick();
    rd_req(32'h208, 11'h022);
    #1;
    chk("cap1_addr", mem_addr_o, 32'h204);
    chk("cap1_rd", mem_rd_o, 1);
    tick();
    idle_req();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("cap_held", mem_rd_o, 0);
      tick();
    end
    mem_ack_i = 1'b1;
    #1;
    chk("ack_cycle_blocked", mem_rd_o, 0);
    chk("ack_cycle_ack", core_ack_o, 1);
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("after_ack_rd", mem_rd_o, 1);
    chk("after_ack_addr", mem_addr_o, 32'h208);
    tick();
    rd_req(32'h20C, 11'h023);
    tick();
    idle_req();
    #1;
    chk("outst_still_2", mem_rd_o, 0);
    tick();

    // Reset with buffered requests drops them
    mem_accept_i = 1'b0;
    rd_req(32'h210, 11'h024);
    #1;
    chk("pre_rst_accept", core_accept_o, 1);
    tick();
    idle_req();
    rst_i = 1'b1; mem_accept_i = 1'b1; mem_ack_i = 1'b1;
    #1;
    chk("midrst_accept", core_accept_o, 0);
    chk("midrst_rd", mem_rd_o, 0);
    chk("midrst_ack_pass", core_ack_o, 1);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = (i == 0);
      #1;
      chk("drop_rd", mem_rd_o, 0);
      chk("drop_wr", mem_wr_o, 0);
      chk("drop_accept", core_accept_o, 1);
      chk("late_ack", core_ack_o, (i == 0) ? 1 : 0);
      tick();
    end
    mem_ack_i = 1'b0;

    // Outstanding count restarts from zero after reset
    rd_req(32'h300, 11'h030);
    tick();
    rd_req(32'h304, 11'h031);
    #1;
    chk("post_rst_rd0", mem_rd_o, 1);
    chk("post_rst_addr0", mem_addr_o, 32'h300);
    tick();
    rd_req(32'h308, 11'h032);
    #1;
    chk("post_rst_rd1", mem_rd_o, 1);
    chk("post_rst_addr1", mem_addr_o, 32'h304);
    tick();
    idle_req();
    #1;
    chk("post_rst_cap", mem_rd_o, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
